param_lifo_stack: RTL and testbench

//   Parametrised LIFO stack; successor to the fixed 8-bit x 32 two-phase stack.

---
 rtl/param_lifo_stack.sv | 124 ++++++++++++
 tb/tb_param_lifo_stack.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/param_lifo_stack.sv
// Parametrised LIFO stack with single-cycle push, pop and replace.
// The top of stack is held in a register so it is visible without popping.
module param_lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic                       err_clr,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             wrEn;
    logic [AW-1:0]    wrAddr;
    logic [AW-1:0]    rdAddr;
    logic             isEmpty;
    logic             isFull;

    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == CW'(DEPTH));

    // Entry just below the current top; only used when count >= 2.
    assign rdAddr = AW'(count_q - CW'(2));

    always_comb begin
        count_d     = count_q;
        dout_d      = dout_q;
        overflow_d  = err_clr ? 1'b0 : overflow_q;
        underflow_d = err_clr ? 1'b0 : underflow_q;
        wrEn        = 1'b0;
        wrAddr      = AW'(count_q);

        if (clear) begin
            count_d = '0;
            dout_d  = '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (isFull) begin
                        overflow_d = 1'b1;
                    end else begin
                        wrEn    = 1'b1;
                        wrAddr  = AW'(count_q);
                        count_d = count_q + CW'(1);
                        dout_d  = din;
                    end
                end
                2'b01: begin
                    if (isEmpty) begin
                        underflow_d = 1'b1;
                    end else if (count_q == CW'(1)) begin
                        count_d = '0;
                        dout_d  = '0;
                    end else begin
                        count_d = count_q - CW'(1);
                        dout_d  = mem_q[rdAddr];
                    end
                end
                2'b11: begin
                    // Simultaneous push and pop replaces the top; on an empty
                    // stack there is nothing to replace so it acts as a push.
                    wrEn   = 1'b1;
                    dout_d = din;
                    if (isEmpty) begin
                        wrAddr  = '0;
                        count_d = CW'(1);
                    end else begin
                        wrAddr = AW'(count_q - CW'(1));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            dout_q      <= dout_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage contents are don't-care until written, so no reset here.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrAddr] <= din;
        end
    end

    assign dout      = dout_q;
    assign count     = count_q;
    assign empty     = isEmpty;
    assign full      = isFull;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_param_lifo_stack.sv
// Directed bench for param_lifo_stack: a 8x32 instance and a 16x5 instance.
module tb_param_lifo_stack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        push = 1'b0, pop = 1'b0, clear = 1'b0, err_clr = 1'b0;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic [5:0]  count;
    logic        empty, full, overflow, underflow;

    logic        pushB = 1'b0, popB = 1'b0, clearB = 1'b0, errClrB = 1'b0;
    logic [15:0] dinB = '0;
    logic [15:0] doutB;
    logic [2:0]  countB;
    logic        emptyB, fullB, overflowB, underflowB;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    param_lifo_stack #(.WIDTH(8), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear),
        .err_clr(err_clr), .din(din), .dout(dout), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    param_lifo_stack #(.WIDTH(16), .DEPTH(5)) dutB (
        .clk(clk), .rst(rst), .push(pushB), .pop(popB), .clear(clearB),
        .err_clr(errClrB), .din(dinB), .dout(doutB), .count(countB),
        .empty(emptyB), .full(fullB), .overflow(overflowB), .underflow(underflowB)
    );

    // Drives one cycle of controls, then returns 1 time unit after the edge.
    task automatic applyStimulus(input logic p, input logic q, input logic c,
                                 input logic e, input logic [7:0] d);
        push = p; pop = q; clear = c; err_clr = e; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0; din = '0;
    endtask

    task automatic applyStimulusB(input logic p, input logic q, input logic [15:0] d);
        pushB = p; popB = q; clearB = 1'b0; errClrB = 1'b0; dinB = d;
        @(posedge clk);
        #1;
        pushB = 1'b0; popB = 1'b0; dinB = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        #12;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_dout", 32'(dout), 32'h00);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);

        // T1: build state (underflow flag, count=5) then async reset mid-cycle
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t1_unf_set", 32'(underflow), 32'd1);
        for (int i = 1; i <= 5; i++) applyStimulus(1, 0, 0, 0, 8'(i));
        checkOutput("t1_count5", 32'(count), 32'd5);
        checkOutput("t1_dout5", 32'(dout), 32'h05);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t1_async_count", 32'(count), 32'd0);
        checkOutput("t1_async_dout", 32'(dout), 32'h00);
        checkOutput("t1_async_empty", 32'(empty), 32'd1);
        checkOutput("t1_async_unf", 32'(underflow), 32'd0);
        checkOutput("t1_async_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // T2: push three then pop three
        applyStimulus(1, 0, 0, 0, 8'h11);
        checkOutput("t2_push1_dout", 32'(dout), 32'h11);
        checkOutput("t2_push1_count", 32'(count), 32'd1);
        applyStimulus(1, 0, 0, 0, 8'h22);
        applyStimulus(1, 0, 0, 0, 8'h33);
        checkOutput("t2_push3_dout", 32'(dout), 32'h33);
        checkOutput("t2_push3_count", 32'(count), 32'd3);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t2_pop1_dout", 32'(dout), 32'h22);
        checkOutput("t2_pop1_count", 32'(count), 32'd2);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t2_pop2_dout", 32'(dout), 32'h11);
        checkOutput("t2_pop2_count", 32'(count), 32'd1);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t2_pop3_dout", 32'(dout), 32'h00);
        checkOutput("t2_pop3_count", 32'(count), 32'd0);
        checkOutput("t2_empty", 32'(empty), 32'd1);

        // T3: fill, overflow, err_clr, replace while full
        for (int i = 0; i < 32; i++) applyStimulus(1, 0, 0, 0, 8'(i));
        checkOutput("t3_full", 32'(full), 32'd1);
        checkOutput("t3_count", 32'(count), 32'd32);
        checkOutput("t3_dout", 32'(dout), 32'd31);
        checkOutput("t3_ovf_before", 32'(overflow), 32'd0);
        applyStimulus(1, 0, 0, 0, 8'hAA);
        checkOutput("t3_ovf_set", 32'(overflow), 32'd1);
        checkOutput("t3_ovf_count", 32'(count), 32'd32);
        checkOutput("t3_ovf_dout", 32'(dout), 32'd31);
        applyStimulus(0, 0, 0, 1, 8'h00);
        checkOutput("t3_errclr", 32'(overflow), 32'd0);
        applyStimulus(1, 1, 0, 0, 8'h55);
        checkOutput("t3_repl_full_dout", 32'(dout), 32'h55);
        checkOutput("t3_repl_full_count", 32'(count), 32'd32);
        checkOutput("t3_repl_full_ovf", 32'(overflow), 32'd0);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t3_pop_dout", 32'(dout), 32'd30);
        checkOutput("t3_pop_count", 32'(count), 32'd31);
        checkOutput("t3_pop_notfull", 32'(full), 32'd0);
        applyStimulus(0, 0, 1, 0, 8'h00);
        checkOutput("t3_clear_count", 32'(count), 32'd0);

        // T4: underflow, push&pop on empty, sticky behaviour
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t4_unf", 32'(underflow), 32'd1);
        checkOutput("t4_unf_count", 32'(count), 32'd0);
        applyStimulus(1, 1, 0, 0, 8'h5A);
        checkOutput("t4_pp_count", 32'(count), 32'd1);
        checkOutput("t4_pp_dout", 32'(dout), 32'h5A);
        checkOutput("t4_unf_sticky", 32'(underflow), 32'd1);
        applyStimulus(0, 0, 1, 0, 8'h00);
        checkOutput("t4_clear_keeps_unf", 32'(underflow), 32'd1);
        applyStimulus(0, 1, 0, 1, 8'h00);
        checkOutput("t4_set_wins", 32'(underflow), 32'd1);
        applyStimulus(0, 0, 0, 1, 8'h00);
        checkOutput("t4_unf_cleared", 32'(underflow), 32'd0);

        // T5: replace top at count 4
        for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 0, 0, 8'(i));
        applyStimulus(1, 1, 0, 0, 8'h77);
        checkOutput("t5_repl_count", 32'(count), 32'd4);
        checkOutput("t5_repl_dout", 32'(dout), 32'h77);
        applyStimulus(0, 1, 0, 0, 8'h00);
        checkOutput("t5_pop_dout", 32'(dout), 32'h03);
        checkOutput("t5_pop_count", 32'(count), 32'd3);

        // T6: clear beats a simultaneous push
        for (int i = 5; i <= 7; i++) applyStimulus(1, 0, 0, 0, 8'(i));
        checkOutput("t6_count6", 32'(count), 32'd6);
        applyStimulus(1, 0, 1, 0, 8'h99);
        checkOutput("t6_clr_count", 32'(count), 32'd0);
        checkOutput("t6_clr_dout", 32'(dout), 32'h00);
        checkOutput("t6_clr_ovf", 32'(overflow), 32'd0);
        checkOutput("t6_clr_unf", 32'(underflow), 32'd0);
        applyStimulus(1, 0, 0, 0, 8'h42);
        checkOutput("t6_after_clr_dout", 32'(dout), 32'h42);

        // T6b: 16-bit, depth-5 instance
        applyStimulusB(1, 0, 16'h1111);
        applyStimulusB(1, 0, 16'h2222);
        applyStimulusB(1, 0, 16'h3333);
        checkOutput("b_push3_dout", 32'(doutB), 32'h3333);
        checkOutput("b_push3_count", 32'(countB), 32'd3);
        applyStimulusB(0, 1, 16'h0000);
        checkOutput("b_pop1_dout", 32'(doutB), 32'h2222);
        applyStimulusB(0, 1, 16'h0000);
        checkOutput("b_pop2_dout", 32'(doutB), 32'h1111);
        applyStimulusB(0, 1, 16'h0000);
        checkOutput("b_pop3_dout", 32'(doutB), 32'h0000);
        checkOutput("b_empty", 32'(emptyB), 32'd1);
        for (int i = 1; i <= 5; i++) applyStimulusB(1, 0, 16'(i * 16'h1010));
        checkOutput("b_full", 32'(fullB), 32'd1);
        checkOutput("b_full_count", 32'(countB), 32'd5);
        applyStimulusB(1, 0, 16'hBEEF);
        checkOutput("b_ovf", 32'(overflowB), 32'd1);
        checkOutput("b_ovf_dout", 32'(doutB), 32'h5050);
        applyStimulusB(0, 1, 16'h0000);
        checkOutput("b_pop_dout", 32'(doutB), 32'h4040);
        checkOutput("b_pop_count", 32'(countB), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
